// File: rtl/addsub_scheduler.sv
// addsub_scheduler
//   Two requesters share a single ripple-carry add/sub datapath. One operation
//   is in flight at a time. The flow is IDLE (grant and capture), then EXEC
//   (compute and register), then RESP (hold the result until the owner takes it).
//   When both requesters are valid, a priority pointer alternates the grant
//   between them, so neither can be starved.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_sub   operands and op select (0 = a+b, 1 = a-b)
//   rspN_valid/ready           response handshake for requester N
//   rsp_data, rsp_ovf          shared result and signed overflow flag
//   busy                       high whenever the FSM is not in IDLE
module addsub_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic             prio_reg;
  logic             owner_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_ovf_reg;

  logic             is_idle;
  logic             pick1;
  logic             accept;
  logic             owner_ready;

  // Grant: requester 1 wins if it is alone, or if both are valid and the
  // pointer currently favours it. Otherwise requester 0 wins.
  assign is_idle     = (state_reg == IDLE);
  assign pick1       = req1_valid & (~req0_valid | prio_reg);
  assign req1_ready  = is_idle & pick1;
  assign req0_ready  = is_idle & req0_valid & ~pick1;
  assign accept      = req0_ready | req1_ready;
  // Only the owner's rsp_ready matters. The other port's ready is ignored.
  assign owner_ready = owner_reg ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (owner_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared ripple-carry datapath: b is inverted bitwise for subtraction, and
  // sub is fed in as the carry-in. The final carry-out is never formed
  // because the result wraps modulo 2^WIDTH.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  assign b_eff    = b_reg ^ {WIDTH{sub_reg}};
  assign carry[0] = sub_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
      assign sum[gi] = a_reg[gi] ^ b_eff[gi] ^ carry[gi];
      if (gi < WIDTH - 1) begin : g_carry
        assign carry[gi+1] = (a_reg[gi] & b_eff[gi]) |
                             (a_reg[gi] & carry[gi]) |
                             (b_eff[gi] & carry[gi]);
      end
    end
  endgenerate

  assign ovf = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_reg[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      prio_reg     <= 1'b0;
      owner_reg    <= 1'b0;
      sub_reg      <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      rsp_data_reg <= '0;
      rsp_ovf_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg <= req1_ready;
            a_reg     <= req1_ready ? req1_a   : req0_a;
            b_reg     <= req1_ready ? req1_b   : req0_b;
            sub_reg   <= req1_ready ? req1_sub : req0_sub;
          end
        end
        EXEC: begin
          rsp_data_reg <= sum;
          rsp_ovf_reg  <= ovf;
        end
        RESP: begin
          if (owner_ready) prio_reg <= ~owner_reg;
        end
        default: ;
      endcase
    end
  end

  assign rsp0_valid = (state_reg == RESP) & ~owner_reg;
  assign rsp1_valid = (state_reg == RESP) &  owner_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_ovf    = rsp_ovf_reg;
  assign busy       = ~is_idle;

endmodule
